rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way-decoded resource (register-file write port or memory port) among 8 requesters.
- Owner index is encoded 3-bit with a matching one-hot grant vector, so it drives resource select directly.
- Grants are held until the owner finishes, drops its request, or hits the hold timeout.
- Sits between the pipeline/requester units and the shared resource's select logic.

Parameters:
- MAX_HOLD, 0: maximum consecutive cycles one owner may hold a grant. 0 = no limit; legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  level request per requester; bit i = requester i
- done  input  1  owner pulses high for one cycle to release; ignored when no grant is held
- grant  output  8  one-hot grant; all zero when idle
- grant_idx  output  3  encoded index of owner; 0 when idle
- grant_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse when MAX_HOLD forces a release

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Invariants, checkable every cycle:
  - grant equals (1 << grant_idx) when grant_valid=1.
  - grant=0 and grant_idx=0 when grant_valid=0.
- IDLE:
  - If req is nonzero at an edge, select the first set bit scanning circularly from ptr: ptr, ptr+1, ..., ptr+7, all mod 8.
  - Register that index into grant_idx/grant, set grant_valid, clear hold counter, go to BUSY.
  - Latency is one cycle: req sampled at edge N gives grant visible after edge N.
  - If req is zero, stay in IDLE.
- BUSY:
  - The hold counter increments every cycle a grant is held, saturating at 255.
  - A release occurs at an edge when any one of these holds:
    - done=1;
    - req[grant_idx]=0;
    - MAX_HOLD!=0 and the counter reaches MAX_HOLD-1 (grant held exactly MAX_HOLD cycles).
  - On release:
    - grant, grant_idx and grant_valid are cleared.
    - ptr = (grant_idx+1) mod 8; wrap from 7 goes to 0.
    - State returns to IDLE.
  - If the release is forced by MAX_HOLD and neither done nor the req drop is also present, timeout pulses high for exactly that one cycle.
- Simultaneous release causes:
  - Release happens once and ptr advances once.
  - timeout is not asserted if done or the req drop coincides with the limit.
- Handoff bubble (default build): after a release, grant_valid stays low for one full cycle before the next grant, even with other requests pending.
- Non-owner requests:
  - Requests from non-owners while BUSY never preempt the owner.
  - They are arbitrated on the next IDLE cycle.
- done in IDLE has no effect.
- Fairness: with all 8 requesting continuously and releasing after one cycle, grant order is 0,1,2,...,7,0,... No requester waits more than 7 grants.
- All outputs are registered. There is no combinational path from req/done to outputs.

Optional Feature:
- Macro: ARB_FAST_HANDOFF_EN.
- Defined:
  - On a release edge, if any req bit other than the releasing owner's is set, arbitrate in the same edge using the updated ptr (owner+1).
  - The new grant is visible the next cycle with grant_valid continuously high; there is no bubble.
  - The hold counter restarts at 0 for the new owner.
  - If no other request is pending, go to IDLE as normal.
  - The releasing owner cannot be regranted in the handoff, even if its req stays high.
- Undefined: the default one-cycle bubble behaviour above.

Test Plan:
- Reset checks:
  - Hold rst_n low 3 cycles with req=8'hFF -> grant=0, grant_idx=0, grant_valid=0.
  - Release reset, next edge -> grant=8'h01, grant_idx=0.
  - Assert rst_n low asynchronously mid-grant -> all outputs 0 before the next clk edge.
- Rotation:
  - req=8'hFF constant, done pulsed every cycle grant_valid=1 -> grant_idx sequence 0,1,...,7,0.
  - Default build: a one-cycle grant_valid=0 gap between each grant.
  - ARB_FAST_HANDOFF_EN build: no gaps.
- Circular scan:
  - After owner 5 releases (ptr=6), req=8'b0001_0100 (bits 2,4) -> grant_idx=2.
  - Then after release, with the same req, -> grant_idx=4.
- Hold/preempt:
  - Owner 3 holds req high 10 cycles with MAX_HOLD=0, req[1] also high -> grant stays 8'h08 all 10 cycles.
  - req[3] drops -> release; the next grant is 1.
- Timeout:
  - MAX_HOLD=4, req=8'h01 held high, no done -> grant_valid high exactly 4 cycles, then timeout=1 for 1 cycle.
  - Then regrant to 0 after the bubble.
  - Variant with done=1 on the 4th cycle -> timeout stays 0.
- Wrap and stray done:
  - Owner 7 releases with req=8'h81 -> next grant_idx=0 (ptr wrapped to 0).
  - done pulse while idle -> no state change.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter for a shared, index-decoded resource.
// A grant is held until the owner pulses done, drops its request, or has held
// the grant for MAX_HOLD cycles (MAX_HOLD = 0 disables the limit).
//
// Optional feature macro: ARB_FAST_HANDOFF_EN
//   undefined : one idle cycle (grant_valid low) between consecutive grants
//   defined   : on a release with other requests pending, the next owner is
//               granted on the same edge, with no bubble
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   req         in   8  level request per requester
//   done        in   1  owner release pulse (ignored while idle)
//   grant       out  8  one-hot grant, zero when idle
//   grant_idx   out  3  encoded owner index, zero when idle
//   grant_valid out  1  a grant is held
//   timeout     out  1  one-cycle pulse when the hold limit forced the release
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    // Counter value on the last permitted cycle of a grant
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          valid_nxt;
    logic          timeout_nxt;
    logic [N-1:0]  grant_nxt;
    logic          rel_done, rel_drop, rel_hold, rel_any;

    // First set bit of r scanning circularly from p; lowest offset wins
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        sel = p;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (r[p + IW'(i)]) begin
                sel = p + IW'(i);
            end
        end
        return sel;
    endfunction

    // Release causes, only meaningful while BUSY
    always_comb begin
        rel_done = done;
        rel_drop = !req[grant_idx];
        rel_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        rel_any  = rel_done || rel_drop || rel_hold;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_cnt_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            timeout     <= timeout_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        idx_nxt      = grant_idx;
        valid_nxt    = grant_valid;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                if (|req) begin
                    idx_nxt      = rr_pick(req, ptr);
                    valid_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (rel_any) begin
                    ptr_nxt      = grant_idx + IW'(1);
                    idx_nxt      = '0;
                    valid_nxt    = 1'b0;
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                    // Pulse only when the limit alone caused the release
                    timeout_nxt  = rel_hold && !rel_done && !rel_drop;
`ifdef ARB_FAST_HANDOFF_EN
                    // Hand off directly; the releasing owner is masked out
                    if (|(req & ~grant)) begin
                        idx_nxt   = rr_pick(req & ~grant, grant_idx + IW'(1));
                        valid_nxt = 1'b1;
                        state_nxt = BUSY;
                    end
`endif
                end else if (hold_cnt != CNT_MAX) begin
                    hold_cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase

        grant_nxt = valid_nxt ? (N'(1) << idx_nxt) : '0;
    end

endmodule
